// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush/redirect controller for the 5-stage LoongArch pipeline.
// Optional build macro PIPELINE_CTRL_PERF_EN adds stall-cycle and redirect counters.
module pipeline_ctrl #(
    parameter int MULTI_CYCLE_LAT = 8,
    parameter int CNT_W           = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_reg1_read_en_i,
    input  logic        id_reg2_read_en_i,
    input  logic [4:0]  id_reg1_read_addr_i,
    input  logic [4:0]  id_reg2_read_addr_i,
    input  logic        ex_is_load_i,
    input  logic        ex_reg_write_en_i,
    input  logic [4:0]  ex_reg_write_addr_i,
    input  logic        ex_multi_start_i,
    input  logic        if_stall_req_i,
    input  logic        mem_stall_req_i,
    input  logic        branch_flush_i,
    input  logic [31:0] branch_target_i,
    output logic [5:0]  stall_o,
    output logic [5:0]  flush_o,
    output logic        new_pc_valid_o,
    output logic [31:0] new_pc_o,
    output logic        multi_busy_o,
`ifdef PIPELINE_CTRL_PERF_EN
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_count_o,
`endif
    output logic        multi_done_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MULTI_CYCLE_LAT - 2);

    generate
        if (MULTI_CYCLE_LAT < 2 || MULTI_CYCLE_LAT > 15) begin : g_badLat
            $error("pipeline_ctrl: MULTI_CYCLE_LAT must be within 2..15");
        end
        if ((1 << CNT_W) <= MULTI_CYCLE_LAT) begin : g_badCntW
            $error("pipeline_ctrl: CNT_W too narrow for MULTI_CYCLE_LAT");
        end
    endgenerate

    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             pendValid_q, pendValid_d;
    logic [31:0]      pendPc_q,   pendPc_d;

    logic multiBusy;
    logic loadUse;
    logic redirectReq;
    logic accept;

    // The op occupies EX for LAT cycles: start cycle, LAT-2 BUSY cycles, one DONE cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (ex_multi_start_i) begin
                    count_d = LOAD_VAL;
                    state_d = (LOAD_VAL == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                count_d = count_q - 1'b1;
                if (count_q <= CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!mem_stall_req_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign multiBusy = (state_q == BUSY) || ((state_q == IDLE) && ex_multi_start_i);

    assign loadUse = ex_is_load_i && ex_reg_write_en_i && (ex_reg_write_addr_i != 5'd0) &&
                     ((id_reg1_read_en_i && (id_reg1_read_addr_i == ex_reg_write_addr_i)) ||
                      (id_reg2_read_en_i && (id_reg2_read_addr_i == ex_reg_write_addr_i)));

    assign redirectReq = branch_flush_i || pendValid_q;
    assign accept      = redirectReq && !mem_stall_req_i && !multiBusy;

    // The instruction in ID is squashed by an accepted redirect, so it must not stall.
    always_comb begin
        stall_o = 6'b000000;
        if (mem_stall_req_i) begin
            stall_o = 6'b011111;
        end else if (multiBusy) begin
            stall_o = 6'b001111;
        end else if (loadUse && !accept) begin
            stall_o = 6'b000111;
        end else if (if_stall_req_i && !accept) begin
            stall_o = 6'b000011;
        end
    end

    always_comb begin
        flush_o        = 6'b000000;
        new_pc_valid_o = 1'b0;
        new_pc_o       = 32'h0;
        if (accept) begin
            flush_o        = 6'b000110;
            new_pc_valid_o = 1'b1;
            new_pc_o       = pendValid_q ? pendPc_q : branch_target_i;
        end
    end

    // The oldest blocked redirect wins; later ones are dropped while it waits.
    always_comb begin
        pendValid_d = pendValid_q;
        pendPc_d    = pendPc_q;
        if (accept) begin
            pendValid_d = 1'b0;
        end else if (branch_flush_i && !pendValid_q) begin
            pendValid_d = 1'b1;
            pendPc_d    = branch_target_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            pendValid_q <= 1'b0;
            pendPc_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pendValid_q <= pendValid_d;
            pendPc_q    <= pendPc_d;
        end
    end

    assign multi_busy_o = multiBusy;
    assign multi_done_o = (state_q == DONE);

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stallCycles_q, stallCycles_d;
    logic [31:0] flushCount_q,  flushCount_d;

    always_comb begin
        stallCycles_d = stallCycles_q;
        flushCount_d  = flushCount_q;
        if (stall_o[0] && (stallCycles_q != 32'hFFFF_FFFF)) begin
            stallCycles_d = stallCycles_q + 32'd1;
        end
        if (accept && (flushCount_q != 32'hFFFF_FFFF)) begin
            flushCount_d = flushCount_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCycles_q <= 32'h0;
            flushCount_q  <= 32'h0;
        end else begin
            stallCycles_q <= stallCycles_d;
            flushCount_q  <= flushCount_d;
        end
    end

    assign stall_cycles_o = stallCycles_q;
    assign flush_count_o  = flushCount_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl with the default MULTI_CYCLE_LAT of 8.
// Expected outputs are queued as each cycle's stimulus is driven and compared at the falling edge.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_reg1_read_en_i;
    logic        id_reg2_read_en_i;
    logic [4:0]  id_reg1_read_addr_i;
    logic [4:0]  id_reg2_read_addr_i;
    logic        ex_is_load_i;
    logic        ex_reg_write_en_i;
    logic [4:0]  ex_reg_write_addr_i;
    logic        ex_multi_start_i;
    logic        if_stall_req_i;
    logic        mem_stall_req_i;
    logic        branch_flush_i;
    logic [31:0] branch_target_i;
    logic [5:0]  stall_o;
    logic [5:0]  flush_o;
    logic        new_pc_valid_o;
    logic [31:0] new_pc_o;
    logic        multi_busy_o;
    logic        multi_done_o;

    typedef struct packed {
        logic [5:0]  stall;
        logic [5:0]  flush;
        logic        pcValid;
        logic [31:0] pc;
        logic        busy;
        logic        done;
    } expResult_t;

    expResult_t expQ[$];
    int checks   = 0;
    int failures = 0;

    pipeline_ctrl #(.MULTI_CYCLE_LAT(8), .CNT_W(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .id_reg1_read_en_i   (id_reg1_read_en_i),
        .id_reg2_read_en_i   (id_reg2_read_en_i),
        .id_reg1_read_addr_i (id_reg1_read_addr_i),
        .id_reg2_read_addr_i (id_reg2_read_addr_i),
        .ex_is_load_i        (ex_is_load_i),
        .ex_reg_write_en_i   (ex_reg_write_en_i),
        .ex_reg_write_addr_i (ex_reg_write_addr_i),
        .ex_multi_start_i    (ex_multi_start_i),
        .if_stall_req_i      (if_stall_req_i),
        .mem_stall_req_i     (mem_stall_req_i),
        .branch_flush_i      (branch_flush_i),
        .branch_target_i     (branch_target_i),
        .stall_o             (stall_o),
        .flush_o             (flush_o),
        .new_pc_valid_o      (new_pc_valid_o),
        .new_pc_o            (new_pc_o),
        .multi_busy_o        (multi_busy_o),
        .multi_done_o        (multi_done_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drives the control inputs and clears the load-use operands; tests set those directly.
    task automatic applyStimulus(input logic memStall, input logic ifStall, input logic multiStart,
                                 input logic branch, input logic [31:0] target);
        mem_stall_req_i     = memStall;
        if_stall_req_i      = ifStall;
        ex_multi_start_i    = multiStart;
        branch_flush_i      = branch;
        branch_target_i     = target;
        id_reg1_read_en_i   = 1'b0;
        id_reg2_read_en_i   = 1'b0;
        id_reg1_read_addr_i = 5'd0;
        id_reg2_read_addr_i = 5'd0;
        ex_is_load_i        = 1'b0;
        ex_reg_write_en_i   = 1'b0;
        ex_reg_write_addr_i = 5'd0;
    endtask

    task automatic expectCycle(input string name, input logic [5:0] s, input logic [5:0] f,
                               input logic pv, input logic [31:0] pc, input logic b, input logic d);
        expResult_t e;
        e.stall   = s;
        e.flush   = f;
        e.pcValid = pv;
        e.pc      = pc;
        e.busy    = b;
        e.done    = d;
        expQ.push_back(e);
        @(negedge clk);
        e = expQ.pop_front();
        checkOutput({name, ".stall"}, 32'(stall_o),        32'(e.stall));
        checkOutput({name, ".flush"}, 32'(flush_o),        32'(e.flush));
        checkOutput({name, ".pcv"},   32'(new_pc_valid_o), 32'(e.pcValid));
        checkOutput({name, ".pc"},    new_pc_o,            e.pc);
        checkOutput({name, ".busy"},  32'(multi_busy_o),   32'(e.busy));
        checkOutput({name, ".done"},  32'(multi_done_o),   32'(e.done));
        @(posedge clk);
        #1;
    endtask

    task automatic setLoadUse(input logic [4:0] wAddr, input logic en1, input logic [4:0] a1,
                              input logic en2, input logic [4:0] a2);
        ex_is_load_i        = 1'b1;
        ex_reg_write_en_i   = 1'b1;
        ex_reg_write_addr_i = wAddr;
        id_reg1_read_en_i   = en1;
        id_reg1_read_addr_i = a1;
        id_reg2_read_en_i   = en2;
        id_reg2_read_addr_i = a2;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        expectCycle("reset", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;

        // Load-use hazards and stall priority
        setLoadUse(5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
        expectCycle("luRj", 6'b000111, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expectCycle("luClear", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        setLoadUse(5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
        expectCycle("luZero", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        setLoadUse(5'd7, 1'b1, 5'd3, 1'b1, 5'd7);
        expectCycle("luRk", 6'b000111, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        setLoadUse(5'd9, 1'b0, 5'd9, 1'b0, 5'd9);
        expectCycle("luNoEn", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        setLoadUse(5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
        expectCycle("prioIfLu", 6'b000111, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expectCycle("ifStall", 6'b000011, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        setLoadUse(5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
        expectCycle("prioMem", 6'b011111, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Multi-cycle op: 7 busy cycles then DONE on the 8th; a start pulse mid-op is ignored
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        expectCycle("mulStart", 6'b001111, 6'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b0, 1'b0, (i == 3), 1'b0, 32'h0);
            expectCycle("mulBusy", 6'b001111, 6'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expectCycle("mulDone", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        expectCycle("mulIdle", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // DONE held while memory stalls
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        expectCycle("holdStart", 6'b001111, 6'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            expectCycle("holdBusy", 6'b001111, 6'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            expectCycle("doneHeld", 6'b011111, 6'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expectCycle("doneRel", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        expectCycle("doneIdle", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Immediate branch redirect, including squash of would-be stalls
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h1c00_0100);
        expectCycle("branch", 6'b0, 6'b000110, 1'b1, 32'h1c00_0100, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h1c00_0180);
        setLoadUse(5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
        expectCycle("brSquash", 6'b0, 6'b000110, 1'b1, 32'h1c00_0180, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expectCycle("brIdle", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Deferred branch: the older target wins when memory releases
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h1c00_0100);
        expectCycle("defer1", 6'b011111, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h1c00_0200);
        expectCycle("defer2", 6'b011111, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expectCycle("deferGo", 6'b0, 6'b000110, 1'b1, 32'h1c00_0100, 1'b0, 1'b0);
        expectCycle("deferIdle", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Branch blocked by a multi-cycle op, accepted in the DONE cycle
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h1c00_0300);
        expectCycle("mulBrStart", 6'b001111, 6'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            expectCycle("mulBrBusy", 6'b001111, 6'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        expectCycle("mulBrDone", 6'b0, 6'b000110, 1'b1, 32'h1c00_0300, 1'b0, 1'b1);
        expectCycle("mulBrIdle", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Reset mid-BUSY drops the FSM and the pending redirect
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h1c00_0400);
        expectCycle("rstStart", 6'b001111, 6'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expectCycle("rstBusy", 6'b001111, 6'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expectCycle("rstQuiet", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        end

        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
